// File: rtl/dac714_pkg.sv
// Shared types and default geometry for the DAC714 serial transmitter.
// Default word width, SCLK half-period and latch pulse width match the board build.
package dac714_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int unsigned DEF_DAC_WIDTH    = 16;
  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_LATCH_CYCLES = 2;

endpackage

// File: rtl/dac714_sclk_gen.sv
// SCLK divider for the DAC714 link: CLK_DIV cycles low, then CLK_DIV cycles high, per bit.
// rise/fall flag the cycle whose closing clock edge toggles the registered SCLK level.
module dac714_sclk_gen
  import dac714_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    wrap      = (div_cnt_q == CW'(CLK_DIV - 1));
    if (clear) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (en) begin
      if (wrap) begin
        div_cnt_d = '0;
        sclk_d    = ~sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + CW'(1);
      end
    end
  end

  assign sclk_rise = en && !clear && wrap && !sclk_q;
  assign sclk_fall = en && !clear && wrap && sclk_q;
  assign sclk      = sclk_q;

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule

// File: rtl/dac714_serial_tx.sv
// DAC714 3-wire serial transmitter with a one-deep pending buffer and busy/done/overrun status.
// Build option: define DAC714_TX_OFFSET_BINARY_EN to send offset binary (MSB inverted at capture).
module dac714_serial_tx
  import dac714_pkg::*;
#(
  parameter int unsigned DAC_WIDTH    = DEF_DAC_WIDTH,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DACStrobe,
  input  logic [DAC_WIDTH-1:0] Yis,
  output logic                 dac_sclk,
  output logic                 dac_sdi,
  output logic                 dac_nlatch,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int unsigned BW = $clog2(DAC_WIDTH + 1);
  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);

  function automatic logic [DAC_WIDTH-1:0] to_dac_code(input logic [DAC_WIDTH-1:0] y);
`ifdef DAC714_TX_OFFSET_BINARY_EN
    return {~y[DAC_WIDTH-1], y[DAC_WIDTH-2:0]};
`else
    return y;
`endif
  endfunction

  state_e               state_q, state_d;
  logic [DAC_WIDTH-1:0] shift_q, shift_d;
  logic [DAC_WIDTH-1:0] pend_word_q, pend_word_d;
  logic                 pend_q, pend_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 last_bit_q, last_bit_d;
  logic [LW-1:0]        lat_cnt_q, lat_cnt_d;
  logic                 busy_q, busy_d;
  logic                 nlatch_q, nlatch_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic                 gen_clear, gen_en, sclk_rise, sclk_fall;
  logic                 last_latch, load_en;
  logic [DAC_WIDTH-1:0] load_word;

  dac714_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (gen_clear),
    .en        (gen_en),
    .sclk      (dac_sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    bit_cnt_d   = bit_cnt_q;
    last_bit_d  = last_bit_q;
    lat_cnt_d   = lat_cnt_q;
    overrun_d   = 1'b0;
    load_en     = 1'b0;
    load_word   = to_dac_code(Yis);
    gen_en      = (state_q == SHIFT);
    last_latch  = (state_q == LATCH) && (lat_cnt_q == LW'(LATCH_CYCLES - 1));

    unique case (state_q)
      IDLE: begin
        load_en = DACStrobe;
      end
      SHIFT: begin
        // The end-of-frame decision is taken at the last rise, so the fall only tests one flop.
        if (sclk_rise) last_bit_d = (bit_cnt_q == BW'(DAC_WIDTH - 1));
        if (sclk_fall) begin
          shift_d = {shift_q[DAC_WIDTH-2:0], 1'b0};
          if (last_bit_q) begin
            state_d   = LATCH;
            lat_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      LATCH: begin
        if (!last_latch) begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end else if (DACStrobe) begin
          load_en   = 1'b1;
          overrun_d = pend_q;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          load_en   = 1'b1;
          load_word = pend_word_q;
          pend_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (DACStrobe && (state_q != IDLE) && !last_latch) begin
      pend_word_d = to_dac_code(Yis);
      pend_d      = 1'b1;
      overrun_d   = pend_q;
    end

    gen_clear = load_en;
    if (load_en) begin
      state_d    = SHIFT;
      shift_d    = load_word;
      bit_cnt_d  = '0;
      last_bit_d = 1'b0;
    end

    busy_d   = (state_d != IDLE);
    nlatch_d = (state_d != LATCH);
    done_d   = (state_d == LATCH) && (lat_cnt_d == LW'(LATCH_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pend_q     <= 1'b0;
      bit_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      lat_cnt_q  <= '0;
      busy_q     <= 1'b0;
      nlatch_q   <= 1'b1;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      lat_cnt_q  <= lat_cnt_d;
      busy_q     <= busy_d;
      nlatch_q   <= nlatch_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: the pending word is pure data qualified by pend_q, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_word_q <= pend_word_d;
  end

  assign dac_sdi    = shift_q[DAC_WIDTH-1];
  assign dac_nlatch = nlatch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
